// File: rtl/microc_stk_if.sv
// Bus bundle between the microc_stk core, its combinational instruction memory
// and the output-port consumer.
interface microc_stk_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 10
) ();
    logic [PC_W-1:0]   instr_addr;
    logic [15:0]       instr;
    logic [5:0]        opcode;
    logic              z;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              stack_err;

    modport master (
        output instr_addr, opcode, z, out_data, out_valid, stack_err,
        input  instr, out_ready
    );

    modport slave (
        input  instr_addr, opcode, z, out_data, out_valid, stack_err,
        output instr, out_ready
    );
endinterface

// File: rtl/microc_stk.sv
// Single-cycle microcontroller core: PC, 16-entry register file, ALU with zero
// flag, hardware return stack (jal/ret) and a stalling valid/ready output port.
module microc_stk #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    microc_stk_if.master bus
);
    // sp counts 0..STACK_DEPTH; the stack array is padded to the full sp range.
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int STK_N = 1 << SP_W;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] regs_d [16];
    logic              z_q, z_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [PC_W-1:0]   stack_q [STK_N];
    logic [PC_W-1:0]   stack_d [STK_N];
    logic              err_q, err_d;

    logic [3:0]        ra_s, rb_s, rd_s;
    logic [2:0]        op_s;
    logic [DATA_W-1:0] a_s, b_s, alu_s, imm_s;
    logic [PC_W-1:0]   pc_inc_s, target_s;
    logic [SP_W-1:0]   sp_dec_s;
    logic              is_out_s, stack_full_s, stack_empty_s;

    assign ra_s     = bus.instr[11:8];
    assign rb_s     = bus.instr[7:4];
    assign rd_s     = bus.instr[3:0];
    assign op_s     = bus.instr[14:12];
    assign a_s      = (ra_s == 4'd0) ? {DATA_W{1'b0}} : regs_q[ra_s];
    assign b_s      = (rb_s == 4'd0) ? {DATA_W{1'b0}} : regs_q[rb_s];
    assign pc_inc_s = pc_q + PC_W'(1'b1);
    assign target_s = bus.instr[PC_W-1:0];
    assign sp_dec_s = sp_q - SP_W'(1'b1);

    assign is_out_s      = (bus.instr[15:12] == 4'b0010);
    assign stack_full_s  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty_s = (sp_q == {SP_W{1'b0}});

    generate
        if (DATA_W >= 8) begin : g_imm_zext
            assign imm_s = DATA_W'(bus.instr[11:4]);
        end else begin : g_imm_trunc
            assign imm_s = bus.instr[4 +: DATA_W];
        end
    endgenerate

    assign bus.instr_addr = pc_q;
    assign bus.opcode     = bus.instr[15:10];
    assign bus.z          = z_q;
    assign bus.stack_err  = err_q;
    assign bus.out_data   = a_s;
    // Masked during reset so a reset cycle can never look like a transfer.
    assign bus.out_valid  = is_out_s & ~reset;

    // ALU datapath
    always_comb begin
        alu_s = {DATA_W{1'b0}};
        case (op_s)
            3'd0:    alu_s = a_s + b_s;
            3'd1:    alu_s = a_s & b_s;
            3'd2:    alu_s = a_s | b_s;
            3'd3:    alu_s = a_s - b_s;
            3'd4:    alu_s = a_s ^ b_s;
            3'd5:    alu_s = ~a_s;
            3'd6:    alu_s = a_s;
            3'd7:    alu_s = {a_s[DATA_W-2:0], 1'b0};
            default: alu_s = {DATA_W{1'b0}};
        endcase
    end

    // Instruction decode and next-state computation
    always_comb begin
        pc_d    = pc_inc_s;
        regs_d  = regs_q;
        z_d     = z_q;
        sp_d    = sp_q;
        stack_d = stack_q;
        err_d   = err_q;
        casez (bus.instr[15:10])
            6'b1?????: begin
                z_d = (alu_s == {DATA_W{1'b0}});
                if (rd_s != 4'd0) regs_d[rd_s] = alu_s;
                else              regs_d[0]    = {DATA_W{1'b0}};
            end
            6'b0001??: begin
                if (rd_s != 4'd0) regs_d[rd_s] = imm_s;
                else              regs_d[0]    = {DATA_W{1'b0}};
            end
            6'b0010??: begin
                if (bus.out_ready) pc_d = pc_inc_s;
                else               pc_d = pc_q;
            end
            6'b010000: pc_d = target_s;
            6'b010001: begin
                if (z_q) pc_d = target_s;
                else     pc_d = pc_inc_s;
            end
            6'b010010: begin
                if (!z_q) pc_d = target_s;
                else      pc_d = pc_inc_s;
            end
            6'b010011: begin
                if (stack_full_s) begin
                    err_d = 1'b1;
                end else begin
                    stack_d[sp_q] = pc_inc_s;
                    sp_d          = sp_q + SP_W'(1'b1);
                    pc_d          = target_s;
                end
            end
            6'b010100: begin
                if (stack_empty_s) begin
                    err_d = 1'b1;
                end else begin
                    sp_d = sp_dec_s;
                    pc_d = stack_q[sp_dec_s];
                end
            end
            default: pc_d = pc_inc_s;
        endcase
    end

    // Architectural state update
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= {PC_W{1'b0}};
            z_q   <= 1'b0;
            sp_q  <= {SP_W{1'b0}};
            err_q <= 1'b0;
            for (int i = 0; i < 16; i++) regs_q[i] <= {DATA_W{1'b0}};
            for (int j = 0; j < STK_N; j++) stack_q[j] <= {PC_W{1'b0}};
        end else begin
            pc_q    <= pc_d;
            z_q     <= z_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            regs_q  <= regs_d;
            stack_q <= stack_d;
        end
    end
endmodule
